// File: rtl/seq_mult_n.sv
// Parametrised sequential add/shift multiplier: WIDTH-bit Switches operand times register B,
// signed or unsigned per start, with Busy/Done handshake and product in {X_out, A_out, B_out}.
`timescale 1ns/1ps
module seq_mult_n #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             CLR_LDB,
  input  logic             Signed_mode,
  input  logic [WIDTH-1:0] Switches,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic             X_out,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] a, b, s;
  logic             x, mode, run_q;
  logic [CNT_W-1:0] count;
  logic             start, last;
  logic [WIDTH:0]   a_ext, s_ext, sum;

  always_comb begin
    start = (state == IDLE) && run_q && !Run;
    last  = (count == LAST);
    a_ext = {mode & a[WIDTH-1], a};
    s_ext = {mode & s[WIDTH-1], s};
    // Signed multiplier's MSB carries negative weight, so its partial product is subtracted.
    sum   = (mode && last) ? a_ext - s_ext : a_ext + s_ext;

    state_d = state;
    case (state)
      IDLE:    if (start) state_d = ADD;
      ADD:     state_d = SHIFT;
      SHIFT:   state_d = last ? DONE : ADD;
      DONE:    if (Run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      a     <= '0;
      b     <= '0;
      s     <= '0;
      x     <= 1'b0;
      mode  <= 1'b0;
      count <= '0;
      run_q <= 1'b0;
    end else begin
      run_q <= Run;
      case (state)
        IDLE: begin
          if (start) begin
            s     <= Switches;
            mode  <= Signed_mode;
            a     <= '0;
            x     <= 1'b0;
            count <= '0;
          end else if (!CLR_LDB) begin
            b <= Switches;
            a <= '0;
            x <= 1'b0;
          end
        end
        ADD: if (b[0]) {x, a} <= sum;
        SHIFT: begin
          {x, a, b} <= {mode & x, x, a, b[WIDTH-1:1]};
          count     <= count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    A_out = a;
    B_out = b;
    X_out = x;
    Busy  = (state == ADD) || (state == SHIFT);
    Done  = (state == DONE);
  end

endmodule

// File: doc/seq_mult_n.md
Name: seq_mult_n

Overview:
- Parametrised successor to the team's 8-bit add/shift multiplier.
- Multiplies a WIDTH-bit multiplicand taken from Switches by a WIDTH-bit multiplier held in register B.
- Runtime mode selects signed (two's complement) or unsigned operation.
- Adds a Busy/Done handshake and latches the multiplicand at start; sits between board switches/buttons and the hex display drivers.

Parameters:
WIDTH, 8, operand width in bits (≥2); product is 2*WIDTH bits {A_out,B_out}, X_out is sign/carry extension
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-low reset
Run  input  1  active-low start button (debounced externally); one multiply per press
CLR_LDB  input  1  active-low: load Switches into B, clear A and X
Signed_mode  input  1  1 = two's complement, 0 = unsigned; sampled at start
Switches  input  WIDTH  operand source (B on CLR_LDB, multiplicand S on start)
A_out  output  WIDTH  accumulator / product upper half
B_out  output  WIDTH  multiplier / product lower half
X_out  output  1  sign (signed) or carry (unsigned) extension bit
Busy  output  1  high while ADD/SHIFT states active
Done  output  1  high in DONE state

Behaviour:
- Reset low (async): A=0, B=0, X=0, S=0, mode=0, count=0, state=IDLE, Busy=0, Done=0, run_q=0. Reset mid-operation aborts immediately; no partial result kept.
- run_q registers Run each cycle. Start = state IDLE & run_q=1 & Run=0 (falling edge). run_q resets to 0, so Run held low through reset release does not start; a release then press is required.
- States: IDLE, ADD, SHIFT, DONE.
- IDLE: if CLR_LDB=0: B<=Switches, A<=0, X<=0. On start: S<=Switches, mode<=Signed_mode, A<=0, X<=0, count<=0, next ADD. If start and CLR_LDB=0 occur in the same cycle, start wins; B keeps its old value.
- ADD: if B[0]=1, {X,A} <= ext(A) ± ext(S), with WIDTH+1-bit arithmetic.
  - Signed: ext = sign-extend; subtract on the last iteration (count=WIDTH-1), otherwise add.
  - Unsigned: ext = zero-extend; always add; X receives the carry.
  - If B[0]=0: no change. Next SHIFT.
- SHIFT: {X,A,B} >>= 1.
  - Signed: X is replicated (arithmetic shift).
  - Unsigned: 0 enters X.
  - count<=count+1; if count=WIDTH-1, next DONE, else ADD.
- DONE: Done=1; hold the result. When Run=1 (released), next IDLE. CLR_LDB is ignored in DONE.
- Latency: start cycle → IDLE→ADD; exactly 2*WIDTH cycles in ADD/SHIFT; Done asserts 2*WIDTH+1 cycles after the start edge is sampled.
- Busy=1 only in ADD/SHIFT. CLR_LDB, Switches and Signed_mode changes are ignored while Busy; the result uses latched S and mode.
- Result: signed product = {X,A,B} sign-consistent, with X=A[WIDTH-1]. Unsigned product = {A,B}, X=0. No overflow is possible.
- Run held low after DONE does not retrigger. A new multiply needs release (DONE→IDLE), then a fresh falling edge.
- Back-to-back multiplies start with A cleared but B holding the previous product low half; the user reloads B via CLR_LDB.

Test Plan:
- WIDTH=8, signed: CLR_LDB pulse with Switches=7, then Switches=-59 (0xC5), Run pulse → after 17 cycles Done=1, A=0xFE, B=0x63, X=1 (-413). Busy high for exactly 16 cycles.
- WIDTH=8, unsigned: B=0xFF, S=0xFF → A=0xFE, B=0x01, X=0. Same data in signed mode → A=0x00, B=0x01 (-1*-1=1).
- WIDTH=8, signed boundaries: -128*-128 → A=0x40, B=0x00, X=0. 0*-128 → all zero. -128*127 → A=0xC0, B=0x80, X=1.
- WIDTH=16, signed: B=300, S=-2 → {A,B}=0xFFFF_FDA8, X=1; Done 33 cycles after start.
- Handshake: hold Run low through DONE → no second multiply; toggling Switches, Signed_mode and CLR_LDB while Busy → result unchanged; CLR_LDB=0 in the same cycle as start → B unchanged, start proceeds.
- Reset: assert Reset mid-SHIFT at count=3 → all outputs 0 asynchronously, state IDLE. Release Reset with Run low → no start until Run goes high then low.
